// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and types for the up/down counter
package counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;
    localparam bit DIR_UP    = 1'b1;
    localparam bit DIR_DN    = 1'b0;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DN   = 2'd3
    } act_e;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle rising-edge qualifier with registered previous value
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse,
    output logic prev
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign prev  = prev_q;
    assign pulse = d & ~prev_q;

endmodule

// File: rtl/updn_counter_mod.sv
// rtl/updn_counter_mod.sv - parametrised up/down counter with load, wrap/saturate and ovf/unf flags
module updn_counter_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0,
    parameter bit               EDGE_DET  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_p,
    input  logic             UHDL,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf,
    output logic             unf
);

    logic             step;
    act_e             act;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    generate
        if (EDGE_DET) begin : g_edge
            logic inc_prev;
            rise_detect u_rise (
                .clk   (clk),
                .reset (reset),
                .d     (inc_p),
                .pulse (step),
                .prev  (inc_prev)
            );
        end else begin : g_level
            assign step = inc_p;
        end
    endgenerate

    // Load wins over a coincident step; the step is dropped, not queued.
    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (step) begin
            act = (UHDL == DIR_UP) ? ACT_UP : ACT_DN;
        end
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (act)
            ACT_LOAD: begin
                q_d = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
            end
            ACT_UP: begin
                if (q_q == MAX_COUNT) begin
                    ovf_d = 1'b1;
                    q_d   = (SATURATE == MODE_SAT) ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end
            ACT_DN: begin
                if (q_q == '0) begin
                    unf_d = 1'b1;
                    q_d   = (SATURATE == MODE_SAT) ? q_q : MAX_COUNT;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign Q       = q_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_max  = (q_q == MAX_COUNT);
    assign at_zero = (q_q == '0);

endmodule

// File: tb/tb_updn_counter_mod.sv
// tb/tb_updn_counter_mod.sv - randomized and directed bench for updn_counter_mod over four configurations
module tb_updn_counter_mod;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inc_p = 1'b0;
    logic        UHDL = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;

    logic [15:0] q0, q1;
    logic [3:0]  q2, q3;
    logic [3:0]  am, az, ov, un;

    int errors = 0;
    int checks = 0;

    int mq[4];
    bit mov[4];
    bit mun[4];
    bit mprev;
    const int mmax[4]  = '{65535, 65535, 9, 9};
    const bit msat[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    const bit medge[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    updn_counter_mod u_def (
        .clk(clk), .reset(reset), .inc_p(inc_p), .UHDL(UHDL), .load(load), .load_val(load_val),
        .Q(q0), .at_max(am[0]), .at_zero(az[0]), .ovf(ov[0]), .unf(un[0])
    );

    updn_counter_mod #(.EDGE_DET(1'b0)) u_lvl (
        .clk(clk), .reset(reset), .inc_p(inc_p), .UHDL(UHDL), .load(load), .load_val(load_val),
        .Q(q1), .at_max(am[1]), .at_zero(az[1]), .ovf(ov[1]), .unf(un[1])
    );

    updn_counter_mod #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) u_w9 (
        .clk(clk), .reset(reset), .inc_p(inc_p), .UHDL(UHDL), .load(load), .load_val(load_val[3:0]),
        .Q(q2), .at_max(am[2]), .at_zero(az[2]), .ovf(ov[2]), .unf(un[2])
    );

    updn_counter_mod #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) u_s9 (
        .clk(clk), .reset(reset), .inc_p(inc_p), .UHDL(UHDL), .load(load), .load_val(load_val[3:0]),
        .Q(q3), .at_max(am[3]), .at_zero(az[3]), .ovf(ov[3]), .unf(un[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    // Reference: range arithmetic modulo MAX+1, clamp in saturate mode.
    task automatic model_tick();
        bit step;
        int lv;
        int m;
        for (int i = 0; i < 4; i++) begin
            m = mmax[i];
            if (reset) begin
                mq[i] = 0; mov[i] = 0; mun[i] = 0;
            end else begin
                step = medge[i] ? (inc_p && !mprev) : inc_p;
                mov[i] = 0; mun[i] = 0;
                if (load) begin
                    lv = (i < 2) ? int'(load_val) : int'(load_val[3:0]);
                    mq[i] = (lv > m) ? m : lv;
                end else if (step && UHDL) begin
                    if (mq[i] == m) mov[i] = 1;
                    if (!(msat[i] && mq[i] == m)) mq[i] = (mq[i] + 1) % (m + 1);
                end else if (step && !UHDL) begin
                    if (mq[i] == 0) mun[i] = 1;
                    if (!(msat[i] && mq[i] == 0)) mq[i] = (mq[i] + m) % (m + 1);
                end
            end
        end
        mprev = reset ? 1'b0 : inc_p;
    endtask

    task automatic cycle();
        logic [31:0] oq[4];
        model_tick();
        @(posedge clk);
        #1;
        oq[0] = 32'(q0); oq[1] = 32'(q1); oq[2] = 32'(q2); oq[3] = 32'(q3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("Q[%0d]", i), oq[i], mq[i]);
            chk($sformatf("at_max[%0d]", i), 32'(am[i]), 32'(mq[i] == mmax[i]));
            chk($sformatf("at_zero[%0d]", i), 32'(az[i]), 32'(mq[i] == 0));
            chk($sformatf("ovf[%0d]", i), 32'(ov[i]), 32'(mov[i]));
            chk($sformatf("unf[%0d]", i), 32'(un[i]), 32'(mun[i]));
        end
    endtask

    task automatic pulse(input bit dir);
        UHDL = dir; inc_p = 1'b1; cycle();
        inc_p = 1'b0; cycle();
    endtask

    initial begin
        int r;
        mprev = 1'b0;
        reset = 1'b1; cycle(); cycle();
        chk("reset_q", 32'(q0), 0);
        chk("reset_at_zero", 32'(az[0]), 1);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) pulse(1'b1);
        chk("up5", 32'(q0), 5);
        for (int k = 0; k < 5; k++) pulse(1'b0);
        chk("dn5", 32'(q0), 0);
        chk("dn5_zero", 32'(az[0]), 1);
        chk("dn5_no_unf", 32'(un[0]), 0);

        UHDL = 1'b1; inc_p = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        inc_p = 1'b0; cycle();
        chk("hold_edge", 32'(q0), 1);
        chk("hold_level", 32'(q1), 4);

        load = 1'b1; load_val = 16'd9; cycle(); load = 1'b0;
        UHDL = 1'b1; inc_p = 1'b1; cycle();
        chk("wrap_up_q", 32'(q2), 0);
        chk("wrap_up_ovf", 32'(ov[2]), 1);
        chk("sat_up_q", 32'(q3), 9);
        chk("sat_up_ovf", 32'(ov[3]), 1);
        inc_p = 1'b0; cycle();
        chk("ovf_clear", 32'(ov[2]), 0);
        pulse(1'b0);
        chk("wrap_dn_q", 32'(q2), 9);
        load = 1'b1; load_val = 16'd0; cycle(); load = 1'b0;
        UHDL = 1'b0; inc_p = 1'b1; cycle();
        chk("sat_dn_q", 32'(q3), 0);
        chk("sat_dn_unf", 32'(un[3]), 1);
        chk("wrap_dn_unf", 32'(un[2]), 1);
        inc_p = 1'b0; cycle();

        load = 1'b1; load_val = 16'd12; cycle(); load = 1'b0;
        chk("load_clamp", 32'(q2), 9);
        chk("load_clamp_max", 32'(am[2]), 1);
        chk("load_wide", 32'(q0), 12);

        load = 1'b1; load_val = 16'd3; UHDL = 1'b1; inc_p = 1'b1; cycle();
        chk("load_vs_step", 32'(q0), 3);
        load = 1'b0; cycle();
        chk("step_not_deferred", 32'(q0), 3);
        inc_p = 1'b0; cycle();

        load = 1'b1; load_val = 16'd7; cycle();
        chk("load7", 32'(q0), 7);
        reset = 1'b1; load = 1'b1; inc_p = 1'b1; cycle();
        chk("reset_mid_q", 32'(q0), 0);
        chk("reset_mid_ovf", 32'(ov[0]), 0);
        reset = 1'b0; load = 1'b0; cycle();
        chk("step_after_reset", 32'(q0), 1);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            inc_p = $urandom_range(0, 1);
            UHDL = (k % 64 < 40) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) UHDL = ~UHDL;
            reset = (r < 2);
            load = (r >= 2 && r < 8);
            case ($urandom_range(0, 3))
                0: load_val = 16'd0;
                1: load_val = 16'd9;
                2: load_val = 16'hFFFF;
                default: load_val = 16'($urandom);
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
